// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_I    = 3'd1,
        RD_D    = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - stateless 2-way round-robin picker
// Ports:
//   req  [1:0]  requests (bit 0 = fetch, bit 1 = data)
//   last        requester granted most recently
//   en          picker enable; no grant when low
//   gnt  [1:0]  one-hot grant (or zero)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // On a tie the requester that did not win last time goes first.
            if (req == 2'b11) begin
                gnt = (last == REQ_D) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing a memory port between fetch and data
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   I_R_*                           fetch read request / completion
//   D_R_*                           data read request / completion
//   D_W_*                           data write request / completion
//   M_R_*                           downstream read channel
//   M_W_*                           downstream write channel
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] I_R_ADDR,
    input  logic                  I_R_ADDR_VALID,
    output logic [DATA_WIDTH-1:0] I_R_DATA,
    output logic                  I_R_DATA_VALID,
    input  logic [ADDR_WIDTH-1:0] D_R_ADDR,
    input  logic                  D_R_ADDR_VALID,
    output logic [DATA_WIDTH-1:0] D_R_DATA,
    output logic                  D_R_DATA_VALID,
    input  logic [ADDR_WIDTH-1:0] D_W_ADDR,
    input  logic [DATA_WIDTH-1:0] D_W_DATA,
    input  logic [1:0]            D_W_SIZE,
    input  logic                  D_W_VALID,
    output logic                  D_W_COMPLETE,
    output logic [ADDR_WIDTH-1:0] M_R_ADDR,
    output logic                  M_R_ADDR_VALID,
    input  logic [DATA_WIDTH-1:0] M_R_DATA,
    input  logic                  M_R_DATA_VALID,
    output logic [ADDR_WIDTH-1:0] M_W_ADDR,
    output logic [DATA_WIDTH-1:0] M_W_DATA,
    output logic [1:0]            M_W_SIZE,
    output logic                  M_W_VALID,
    input  logic                  M_W_READY,
    input  logic                  M_W_COMPLETE
);

    arb_state_t state;
    req_id_t    rr_last;
    logic       masked_i;
    logic       masked_d;
    logic       pend_i;
    logic       pend_d;
    logic [1:0] gnt;
    logic       w_accept;
    logic       wr_done;

    // A requester that just completed is hidden for one IDLE cycle so it
    // has time to drop its held valid before it could be granted again.
    assign pend_i = I_R_ADDR_VALID & ~masked_i;
    assign pend_d = (D_W_VALID | D_R_ADDR_VALID) & ~masked_d;

    rr_arb2 u_rr_arb2 (
        .req  ({pend_d, pend_i}),
        .last (rr_last),
        .en   (state == IDLE),
        .gnt  (gnt)
    );

    assign w_accept = (state == WR_REQ) & M_W_VALID & M_W_READY;
    // A completion coinciding with acceptance counts as the completion.
    assign wr_done  = ((state == WR_WAIT) | w_accept) & M_W_COMPLETE;

    // Responses are forwarded only to the owner of the outstanding read;
    // anything arriving in another state is dropped.
    assign I_R_DATA_VALID = (state == RD_I) & M_R_DATA_VALID;
    assign D_R_DATA_VALID = (state == RD_D) & M_R_DATA_VALID;
    assign I_R_DATA       = I_R_DATA_VALID ? M_R_DATA : '0;
    assign D_R_DATA       = D_R_DATA_VALID ? M_R_DATA : '0;
    assign D_W_COMPLETE   = wr_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_last        <= REQ_D;
            masked_i       <= 1'b0;
            masked_d       <= 1'b0;
            M_R_ADDR       <= '0;
            M_R_ADDR_VALID <= 1'b0;
            M_W_ADDR       <= '0;
            M_W_DATA       <= '0;
            M_W_SIZE       <= 2'b00;
            M_W_VALID      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    masked_i <= 1'b0;
                    masked_d <= 1'b0;
                    if (gnt[0]) begin
                        rr_last        <= REQ_I;
                        state          <= RD_I;
                        M_R_ADDR       <= I_R_ADDR;
                        M_R_ADDR_VALID <= 1'b1;
                    end else if (gnt[1]) begin
                        rr_last <= REQ_D;
                        // A pending data write is issued ahead of a pending data read.
                        if (D_W_VALID) begin
                            state     <= WR_REQ;
                            M_W_ADDR  <= D_W_ADDR;
                            M_W_DATA  <= D_W_DATA;
                            M_W_SIZE  <= D_W_SIZE;
                            M_W_VALID <= 1'b1;
                        end else begin
                            state          <= RD_D;
                            M_R_ADDR       <= D_R_ADDR;
                            M_R_ADDR_VALID <= 1'b1;
                        end
                    end
                end
                RD_I, RD_D: begin
                    if (M_R_DATA_VALID) begin
                        M_R_ADDR_VALID <= 1'b0;
                        state          <= IDLE;
                        if (state == RD_I) masked_i <= 1'b1;
                        else               masked_d <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (w_accept) begin
                        M_W_VALID <= 1'b0;
                        if (M_W_COMPLETE) begin
                            state    <= IDLE;
                            masked_d <= 1'b1;
                        end else begin
                            state <= WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (M_W_COMPLETE) begin
                        state    <= IDLE;
                        masked_d <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [63:0] I_R_ADDR;
    logic        I_R_ADDR_VALID;
    logic [63:0] I_R_DATA;
    logic        I_R_DATA_VALID;
    logic [63:0] D_R_ADDR;
    logic        D_R_ADDR_VALID;
    logic [63:0] D_R_DATA;
    logic        D_R_DATA_VALID;
    logic [63:0] D_W_ADDR;
    logic [63:0] D_W_DATA;
    logic [1:0]  D_W_SIZE;
    logic        D_W_VALID;
    logic        D_W_COMPLETE;
    logic [63:0] M_R_ADDR;
    logic        M_R_ADDR_VALID;
    logic [63:0] M_R_DATA;
    logic        M_R_DATA_VALID;
    logic [63:0] M_W_ADDR;
    logic [63:0] M_W_DATA;
    logic [1:0]  M_W_SIZE;
    logic        M_W_VALID;
    logic        M_W_READY;
    logic        M_W_COMPLETE;

    mem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .I_R_ADDR       (I_R_ADDR),
        .I_R_ADDR_VALID (I_R_ADDR_VALID),
        .I_R_DATA       (I_R_DATA),
        .I_R_DATA_VALID (I_R_DATA_VALID),
        .D_R_ADDR       (D_R_ADDR),
        .D_R_ADDR_VALID (D_R_ADDR_VALID),
        .D_R_DATA       (D_R_DATA),
        .D_R_DATA_VALID (D_R_DATA_VALID),
        .D_W_ADDR       (D_W_ADDR),
        .D_W_DATA       (D_W_DATA),
        .D_W_SIZE       (D_W_SIZE),
        .D_W_VALID      (D_W_VALID),
        .D_W_COMPLETE   (D_W_COMPLETE),
        .M_R_ADDR       (M_R_ADDR),
        .M_R_ADDR_VALID (M_R_ADDR_VALID),
        .M_R_DATA       (M_R_DATA),
        .M_R_DATA_VALID (M_R_DATA_VALID),
        .M_W_ADDR       (M_W_ADDR),
        .M_W_DATA       (M_W_DATA),
        .M_W_SIZE       (M_W_SIZE),
        .M_W_VALID      (M_W_VALID),
        .M_W_READY      (M_W_READY),
        .M_W_COMPLETE   (M_W_COMPLETE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: who owns the port, what was captured at
    // grant, who won last, and who completed in the previous cycle.
    bit          m_busy;
    int          m_kind;      // 0 fetch read, 1 data read, 2 data write
    bit          m_acc;       // write accepted downstream, awaiting completion
    int          m_last;      // 0 fetch, 1 data
    bit          m_mask_i;
    bit          m_mask_d;
    logic [63:0] e_raddr;
    logic [63:0] e_waddr;
    logic [63:0] e_wdata;
    logic [1:0]  e_wsize;
    bit          done_i;
    bit          done_dr;
    bit          done_dw;
    bit          new_txn;

    task automatic model_cycle();
        bit exp_ip;
        bit exp_dp;
        bit exp_wc;
        bit ei;
        bit ed;
        int win;
        check("m_r_valid", 64'(M_R_ADDR_VALID), 64'(m_busy && m_kind != 2));
        check("m_r_addr", M_R_ADDR, e_raddr);
        check("m_w_valid", 64'(M_W_VALID), 64'(m_busy && m_kind == 2 && !m_acc));
        check("m_w_addr", M_W_ADDR, e_waddr);
        check("m_w_data", M_W_DATA, e_wdata);
        check("m_w_size", 64'(M_W_SIZE), 64'(e_wsize));
        check("one_outstanding", 64'(M_R_ADDR_VALID & M_W_VALID), 64'd0);
        exp_ip = m_busy && m_kind == 0 && M_R_DATA_VALID;
        exp_dp = m_busy && m_kind == 1 && M_R_DATA_VALID;
        exp_wc = m_busy && m_kind == 2 && M_W_COMPLETE && (m_acc || M_W_READY);
        check("i_pulse", 64'(I_R_DATA_VALID), 64'(exp_ip));
        if (exp_ip) check("i_data", I_R_DATA, M_R_DATA);
        check("d_pulse", 64'(D_R_DATA_VALID), 64'(exp_dp));
        if (exp_dp) check("d_data", D_R_DATA, M_R_DATA);
        check("w_complete", 64'(D_W_COMPLETE), 64'(exp_wc));
        done_i = 0; done_dr = 0; done_dw = 0; new_txn = 0;
        if (reset) begin
            m_busy = 0; m_acc = 0; m_last = 1; m_mask_i = 0; m_mask_d = 0;
            e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wsize = '0;
        end else if (!m_busy) begin
            ei = I_R_ADDR_VALID && !m_mask_i;
            ed = (D_W_VALID || D_R_ADDR_VALID) && !m_mask_d;
            m_mask_i = 0;
            m_mask_d = 0;
            if (ei && ed) win = (m_last == 1) ? 0 : 1;
            else if (ei)  win = 0;
            else if (ed)  win = 1;
            else          win = -1;
            if (win == 0) begin
                m_busy = 1; m_kind = 0; m_last = 0; e_raddr = I_R_ADDR; new_txn = 1;
            end else if (win == 1) begin
                m_busy = 1; m_last = 1; new_txn = 1;
                if (D_W_VALID) begin
                    m_kind = 2; m_acc = 0;
                    e_waddr = D_W_ADDR; e_wdata = D_W_DATA; e_wsize = D_W_SIZE;
                end else begin
                    m_kind = 1; e_raddr = D_R_ADDR;
                end
            end
        end else if (m_kind < 2) begin
            if (M_R_DATA_VALID) begin
                m_busy = 0;
                if (m_kind == 0) begin m_mask_i = 1; done_i = 1; end
                else begin m_mask_d = 1; done_dr = 1; end
            end
        end else begin
            if (exp_wc) begin
                m_busy = 0; m_acc = 0; m_mask_d = 1; done_dw = 1;
            end else if (!m_acc && M_W_READY) begin
                m_acc = 1;
            end
        end
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        I_R_ADDR_VALID = 0; D_R_ADDR_VALID = 0; D_W_VALID = 0;
        M_R_DATA_VALID = 0; M_W_READY = 0; M_W_COMPLETE = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    logic [63:0] order[4];
    int          n_rd;
    int          ord;
    int          order_w;
    int          order_r;
    bit          wdone;
    bit          rdone;
    bit          i_pend, dr_pend, dw_pend;
    int unsigned i_gap, dr_gap, dw_gap, rlat, wlat;

    initial begin
        reset = 1;
        I_R_ADDR = '0; D_R_ADDR = '0; D_W_ADDR = '0; D_W_DATA = '0; D_W_SIZE = '0;
        M_R_DATA = '0;
        clear_inputs();
        m_busy = 0; m_kind = 0; m_acc = 0; m_last = 1; m_mask_i = 0; m_mask_d = 0;
        e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wsize = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_r_valid", 64'(M_R_ADDR_VALID), 64'd0);
        check("rst_w_valid", 64'(M_W_VALID), 64'd0);
        check("rst_w_addr", M_W_ADDR, 64'd0);

        // Lone fetch read; response three cycles after the request.
        I_R_ADDR = 64'h1000; I_R_ADDR_VALID = 1;
        step();
        check("t1_r_valid", 64'(M_R_ADDR_VALID), 64'd1);
        check("t1_r_addr", M_R_ADDR, 64'h1000);
        I_R_ADDR = 64'hFFFF;
        step();
        step();
        M_R_DATA = 64'hAA; M_R_DATA_VALID = 1;
        #1;
        check("t1_i_pulse", 64'(I_R_DATA_VALID), 64'd1);
        check("t1_i_data", I_R_DATA, 64'hAA);
        check("t1_d_quiet", 64'(D_R_DATA_VALID), 64'd0);
        step();
        I_R_ADDR_VALID = 0; M_R_DATA_VALID = 0;
        step();
        step();

        // Fetch and data reads held together after reset: I, D, I, D.
        do_reset();
        I_R_ADDR = 64'h1000; I_R_ADDR_VALID = 1;
        D_R_ADDR = 64'h2000; D_R_ADDR_VALID = 1;
        n_rd = 0;
        for (int cyc = 0; cyc < 40 && n_rd < 4; cyc++) begin
            M_R_DATA = 64'h5A00 + 64'(cyc);
            M_R_DATA_VALID = M_R_ADDR_VALID;
            if (M_R_ADDR_VALID) begin
                order[n_rd] = M_R_ADDR;
                n_rd++;
            end
            step();
        end
        check("t2_count", 64'(n_rd), 64'd4);
        check("t2_g0", order[0], 64'h1000);
        check("t2_g1", order[1], 64'h2000);
        check("t2_g2", order[2], 64'h1000);
        check("t2_g3", order[3], 64'h2000);
        clear_inputs();
        step();
        step();

        // Write with two stalled cycles, completion two cycles after acceptance.
        D_W_ADDR = 64'h40; D_W_DATA = 64'hDEAD; D_W_SIZE = 2'd3; D_W_VALID = 1; M_W_READY = 0;
        step();
        for (int k = 0; k < 3; k++) begin
            check("t3_w_valid", 64'(M_W_VALID), 64'd1);
            check("t3_w_addr", M_W_ADDR, 64'h40);
            check("t3_w_data", M_W_DATA, 64'hDEAD);
            check("t3_w_size", 64'(M_W_SIZE), 64'd3);
            D_W_ADDR = 64'(k + 1);
            D_W_DATA = 64'(k + 7);
            M_W_READY = (k == 2);
            step();
        end
        M_W_READY = 0;
        check("t3_w_drop", 64'(M_W_VALID), 64'd0);
        step();
        M_W_COMPLETE = 1;
        #1;
        check("t3_w_complete", 64'(D_W_COMPLETE), 64'd1);
        step();
        D_W_VALID = 0;
        #1;
        check("t3_single_pulse", 64'(D_W_COMPLETE), 64'd0);
        step();
        clear_inputs();
        step();

        // Data write and data read together: write goes out first.
        D_W_ADDR = 64'h80; D_W_DATA = 64'h1234; D_W_SIZE = 2'd1; D_W_VALID = 1;
        D_R_ADDR = 64'h90; D_R_ADDR_VALID = 1;
        ord = 0; order_w = 99; order_r = 99; rdone = 0;
        for (int cyc = 0; cyc < 20 && !rdone; cyc++) begin
            M_W_READY = M_W_VALID; M_W_COMPLETE = M_W_VALID;
            M_R_DATA = 64'h77; M_R_DATA_VALID = M_R_ADDR_VALID;
            if (M_W_VALID && order_w == 99) begin order_w = ord; ord++; end
            if (M_R_ADDR_VALID && order_r == 99) begin order_r = ord; ord++; end
            #1;
            wdone = D_W_COMPLETE;
            rdone = D_R_DATA_VALID;
            step();
            if (wdone) D_W_VALID = 0;
            if (rdone) D_R_ADDR_VALID = 0;
        end
        check("t4_write_first", 64'(order_w), 64'd0);
        check("t4_read_second", 64'(order_r), 64'd1);
        check("t4_read_done", 64'(rdone), 64'd1);
        clear_inputs();
        step();

        // Reset while a data read waits; the late response must be dropped.
        D_R_ADDR = 64'h2000; D_R_ADDR_VALID = 1;
        step();
        step();
        reset = 1; D_R_ADDR_VALID = 0;
        step();
        reset = 0;
        check("t5_r_valid", 64'(M_R_ADDR_VALID), 64'd0);
        M_R_DATA = 64'h55; M_R_DATA_VALID = 1;
        #1;
        check("t5_d_dropped", 64'(D_R_DATA_VALID), 64'd0);
        step();
        M_R_DATA_VALID = 0;
        I_R_ADDR = 64'h3000; I_R_ADDR_VALID = 1;
        step();
        check("t5_i_addr", M_R_ADDR, 64'h3000);
        M_R_DATA = 64'h66; M_R_DATA_VALID = 1;
        #1;
        check("t5_i_pulse", 64'(I_R_DATA_VALID), 64'd1);
        step();
        clear_inputs();
        step();

        // Spurious downstream pulses while idle.
        for (int k = 0; k < 3; k++) begin
            M_W_COMPLETE = 1; M_R_DATA_VALID = 1; M_W_READY = 1;
            #1;
            check("t6_no_w_pulse", 64'(D_W_COMPLETE), 64'd0);
            check("t6_no_r_pulse", 64'(I_R_DATA_VALID | D_R_DATA_VALID), 64'd0);
            step();
        end
        clear_inputs();
        step();

        // Randomised traffic against the reference model.
        i_pend = 0; dr_pend = 0; dw_pend = 0;
        i_gap = 0; dr_gap = 1; dw_gap = 2; rlat = 0; wlat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!i_pend) begin
                if (i_gap == 0) begin i_pend = 1; I_R_ADDR = {$urandom, $urandom}; end
                else i_gap--;
            end else if ($urandom % 4 == 0) I_R_ADDR = {$urandom, $urandom};
            if (!dr_pend) begin
                if (dr_gap == 0) begin dr_pend = 1; D_R_ADDR = {$urandom, $urandom}; end
                else dr_gap--;
            end else if ($urandom % 4 == 0) D_R_ADDR = {$urandom, $urandom};
            if (!dw_pend) begin
                if (dw_gap == 0) begin
                    dw_pend = 1;
                    D_W_ADDR = {$urandom, $urandom};
                    D_W_DATA = {$urandom, $urandom};
                    D_W_SIZE = 2'($urandom % 4);
                end else dw_gap--;
            end else if ($urandom % 4 == 0) begin
                D_W_ADDR = {$urandom, $urandom};
                D_W_DATA = {$urandom, $urandom};
                D_W_SIZE = 2'($urandom % 4);
            end
            I_R_ADDR_VALID = i_pend;
            D_R_ADDR_VALID = dr_pend;
            D_W_VALID = dw_pend;

            M_R_DATA = {$urandom, $urandom};
            if (m_busy && m_kind < 2) begin
                if (rlat == 0) M_R_DATA_VALID = 1;
                else begin M_R_DATA_VALID = 0; rlat--; end
            end else begin
                M_R_DATA_VALID = ($urandom % 8 == 0);
            end
            M_W_READY = ($urandom % 2 == 1);
            if (m_busy && m_kind == 2) begin
                if (!m_acc) M_W_COMPLETE = M_W_READY && ($urandom % 3 == 0);
                else if (wlat == 0) M_W_COMPLETE = 1;
                else begin M_W_COMPLETE = 0; wlat--; end
            end else begin
                M_W_COMPLETE = ($urandom % 8 == 0);
            end

            step();

            if (new_txn) begin rlat = $urandom_range(3, 0); wlat = $urandom_range(3, 0); end
            if (done_i)  begin i_pend = 0;  i_gap = $urandom_range(3, 0); end
            if (done_dr) begin dr_pend = 0; dr_gap = $urandom_range(4, 0); end
            if (done_dw) begin dw_pend = 0; dw_gap = $urandom_range(5, 0); end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
